// File: rtl/s10_user_io_ctrl_if.sv
// User I/O bundle for the board-level switch/button/LED controller.
// The master drives raw pins, the LED write port and lamp test. The slave
// returns debounced levels, edge pulses, the write error flag and LED pins.
interface s10_user_io_ctrl_if #(
  parameter int N_IN     = 7,
  parameter int N_LED    = 8,
  parameter int PWM_BITS = 8
);
  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

  logic [N_IN-1:0]     raw_in;
  logic [N_IN-1:0]     db_level;
  logic [N_IN-1:0]     db_rise;
  logic [N_IN-1:0]     db_fall;
  logic                led_wr_en;
  logic [IDX_W-1:0]    led_wr_idx;
  logic [1:0]          led_wr_mode;
  logic [PWM_BITS-1:0] led_wr_duty;
  logic                led_wr_err;
  logic                led_test;
  logic [N_LED-1:0]    led_out;

  modport master (
    output raw_in, led_wr_en, led_wr_idx, led_wr_mode, led_wr_duty, led_test,
    input  db_level, db_rise, db_fall, led_wr_err, led_out
  );

  modport slave (
    input  raw_in, led_wr_en, led_wr_idx, led_wr_mode, led_wr_duty, led_test,
    output db_level, db_rise, db_fall, led_wr_err, led_out
  );
endinterface

// File: rtl/s10_user_io_ctrl.sv
// Board user-I/O controller: debounces pushbuttons/DIP switches and drives
// LED channels in off / on / blink / PWM modes with a lamp-test override.
// All state runs on clk_fpga_50m; cpu_reset is asynchronous, active-high.
module s10_user_io_ctrl #(
  parameter int              N_IN         = 7,
  parameter logic [N_IN-1:0] IN_RST_VAL   = 7'h7F,
  parameter int              DB_CYCLES    = 500000,
  parameter int              N_LED        = 8,
  parameter int              BLINK_CYCLES = 12500000,
  parameter int              PWM_BITS     = 8,
  parameter int              LED_ACT_LOW  = 1
) (
  input logic              clk_fpga_50m,
  input logic              cpu_reset,
  s10_user_io_ctrl_if.slave io
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int PRE_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_CYCLES - 1);
  localparam logic [N_LED-1:0] UNLIT    = (LED_ACT_LOW != 0) ? {N_LED{1'b1}}
                                                             : {N_LED{1'b0}};

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  // Two-flop synchronizer stages for the asynchronous pins
  logic [N_IN-1:0] sync_p0;
  logic [N_IN-1:0] sync_p1;

  // Debounce state
  logic [CNT_W-1:0] db_cnt [N_IN];
  logic [N_IN-1:0]  db_level_q;
  logic [N_IN-1:0]  db_rise_q;
  logic [N_IN-1:0]  db_fall_q;

  // LED configuration and shared timing
  logic [1:0]          mode_q [N_LED];
  logic [PWM_BITS-1:0] duty_q [N_LED];
  logic                wr_in_range;
  logic                wr_ok;
  logic                wr_err_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    blink_pre;
  logic                blink_phase;
  logic [N_LED-1:0]    lit;
  logic [N_LED-1:0]    led_out_q;

  // Synchronize raw pins; reset loads the idle level so release is glitch-free
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      sync_p0 <= IN_RST_VAL;
      sync_p1 <= IN_RST_VAL;
    end else begin
      sync_p0 <= io.raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-input persistence counter; the level flips on the DB_CYCLES-th
  // consecutive differing cycle and the matching edge pulse fires with it
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int i = 0; i < N_IN; i++) begin
        db_cnt[i] <= '0;
      end
      db_level_q <= IN_RST_VAL;
      db_rise_q  <= '0;
      db_fall_q  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        db_rise_q[i] <= 1'b0;
        db_fall_q[i] <= 1'b0;
        if (sync_p1[i] == db_level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]     <= '0;
          db_level_q[i] <= sync_p1[i];
          db_rise_q[i]  <= sync_p1[i];
          db_fall_q[i]  <= ~sync_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign wr_in_range = (int'(io.led_wr_idx) < N_LED);
  assign wr_ok       = io.led_wr_en && wr_in_range;

  // Channel mode/duty registers; out-of-range writes are dropped
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      for (int i = 0; i < N_LED; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mode_q[io.led_wr_idx] <= io.led_wr_mode;
      duty_q[io.led_wr_idx] <= io.led_wr_duty;
    end
  end

  // One-cycle error flag for a write aimed past the last channel
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= io.led_wr_en && !wr_in_range;
    end
  end

  // Free-running PWM counter shared by every PWM channel; wraps naturally
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink prescaler toggles the common phase so all blink channels stay in step
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      blink_pre   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_pre == PRE_LAST) begin
      blink_pre   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_pre <= blink_pre + PRE_W'(1);
    end
  end

  // Per-channel lit decision; lamp test overrides without touching registers
  always_comb begin
    lit = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_q[i])
        MODE_OFF:   lit[i] = 1'b0;
        MODE_ON:    lit[i] = 1'b1;
        MODE_BLINK: lit[i] = blink_phase;
        MODE_PWM:   lit[i] = (pwm_cnt < duty_q[i]);
        default:    lit[i] = 1'b0;
      endcase
    end
    if (io.led_test) begin
      lit = '1;
    end
  end

  // Registered LED pins with board polarity applied
  always_ff @(posedge clk_fpga_50m or posedge cpu_reset) begin
    if (cpu_reset) begin
      led_out_q <= UNLIT;
    end else begin
      led_out_q <= lit ^ UNLIT;
    end
  end

  assign io.db_level   = db_level_q;
  assign io.db_rise    = db_rise_q;
  assign io.db_fall    = db_fall_q;
  assign io.led_wr_err = wr_err_q;
  assign io.led_out    = led_out_q;

endmodule

// File: tb/tb_s10_user_io_ctrl.sv
// Directed bench for s10_user_io_ctrl: an 8-LED instance covers debounce,
// PWM, blink, lamp test and reset; a 6-LED instance covers write errors.
module tb_s10_user_io_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  s10_user_io_ctrl_if #(.N_IN(7), .N_LED(8), .PWM_BITS(3)) u ();
  s10_user_io_ctrl_if #(.N_IN(7), .N_LED(6), .PWM_BITS(3)) v ();

  s10_user_io_ctrl #(
    .N_IN(7), .IN_RST_VAL(7'h7F), .DB_CYCLES(4), .N_LED(8),
    .BLINK_CYCLES(3), .PWM_BITS(3), .LED_ACT_LOW(1)
  ) dut (
    .clk_fpga_50m(clk), .cpu_reset(rst), .io(u)
  );

  s10_user_io_ctrl #(
    .N_IN(7), .IN_RST_VAL(7'h7F), .DB_CYCLES(4), .N_LED(6),
    .BLINK_CYCLES(3), .PWM_BITS(3), .LED_ACT_LOW(1)
  ) dut6 (
    .clk_fpga_50m(clk), .cpu_reset(rst), .io(v)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic led_write(input logic [2:0] idx, input logic [1:0] mode,
                           input logic [2:0] duty);
    u.led_wr_en   = 1'b1;
    u.led_wr_idx  = idx;
    u.led_wr_mode = mode;
    u.led_wr_duty = duty;
    tick();
    u.led_wr_en = 1'b0;
  endtask

  task automatic led6_write(input logic [2:0] idx, input logic [1:0] mode,
                            input logic [2:0] duty);
    v.led_wr_en   = 1'b1;
    v.led_wr_idx  = idx;
    v.led_wr_mode = mode;
    v.led_wr_duty = duty;
    tick();
    v.led_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vec++; if (u.db_level !== 7'h7F) begin miss++; $display("FAIL reset_db_level got %h want 7f", u.db_level); end
    vec++; if (u.db_rise !== 7'h00 || u.db_fall !== 7'h00) begin miss++; $display("FAIL reset_pulses got rise %h fall %h want 00 00", u.db_rise, u.db_fall); end
    vec++; if (u.led_wr_err !== 1'b0) begin miss++; $display("FAIL reset_err got %b want 0", u.led_wr_err); end
    vec++; if (u.led_out !== 8'hFF) begin miss++; $display("FAIL reset_led_out got %h want ff", u.led_out); end
    vec++; if (v.led_out !== 6'h3F) begin miss++; $display("FAIL reset_led6_out got %h want 3f", v.led_out); end
    rst = 1'b0;
    tick();
    vec++; if (u.led_out !== 8'hFF) begin miss++; $display("FAIL post_reset_led_out got %h want ff", u.led_out); end
  endtask

  task automatic test_debounce_fall();
    u.raw_in[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++; if (u.db_level[0] !== ((k >= 6) ? 1'b0 : 1'b1)) begin miss++; $display("FAIL fall_level edge %0d got %b want %b", k, u.db_level[0], (k >= 6) ? 1'b0 : 1'b1); end
      vec++; if (u.db_fall[0] !== (k == 6)) begin miss++; $display("FAIL fall_pulse edge %0d got %b want %b", k, u.db_fall[0], k == 6); end
      vec++; if (u.db_rise[0] !== 1'b0) begin miss++; $display("FAIL fall_no_rise edge %0d got %b want 0", k, u.db_rise[0]); end
    end
  endtask

  task automatic test_debounce_rise();
    u.raw_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++; if (u.db_level[0] !== ((k >= 6) ? 1'b1 : 1'b0)) begin miss++; $display("FAIL rise_level edge %0d got %b want %b", k, u.db_level[0], (k >= 6) ? 1'b1 : 1'b0); end
      vec++; if (u.db_rise[0] !== (k == 6)) begin miss++; $display("FAIL rise_pulse edge %0d got %b want %b", k, u.db_rise[0], k == 6); end
      vec++; if (u.db_fall[0] !== 1'b0) begin miss++; $display("FAIL rise_no_fall edge %0d got %b want 0", k, u.db_fall[0]); end
    end
  endtask

  task automatic test_glitch_short();
    for (int k = 1; k <= 15; k++) begin
      u.raw_in[1] = (k <= 3) ? 1'b0 : 1'b1;
      tick();
      vec++; if (u.db_level[1] !== 1'b1 || u.db_rise[1] !== 1'b0 || u.db_fall[1] !== 1'b0) begin
        miss++; $display("FAIL glitch3 edge %0d got lvl %b rise %b fall %b want 1 0 0", k, u.db_level[1], u.db_rise[1], u.db_fall[1]);
      end
    end
  endtask

  task automatic test_glitch_boundary();
    for (int k = 1; k <= 16; k++) begin
      u.raw_in[2] = (k <= 4) ? 1'b0 : 1'b1;
      tick();
      vec++; if (u.db_level[2] !== ((k >= 6 && k < 10) ? 1'b0 : 1'b1)) begin miss++; $display("FAIL glitch4_level edge %0d got %b want %b", k, u.db_level[2], (k >= 6 && k < 10) ? 1'b0 : 1'b1); end
      vec++; if (u.db_fall[2] !== (k == 6) || u.db_rise[2] !== (k == 10)) begin
        miss++; $display("FAIL glitch4_pulse edge %0d got fall %b rise %b want %b %b", k, u.db_fall[2], u.db_rise[2], k == 6, k == 10);
      end
    end
  endtask

  task automatic test_pwm();
    int lows;
    led_write(3'd2, 2'b11, 3'd3);
    vec++; if (u.led_wr_err !== 1'b0) begin miss++; $display("FAIL pwm_write_err got %b want 0", u.led_wr_err); end
    tick();
    for (int w = 0; w < 2; w++) begin
      lows = 0;
      for (int k = 0; k < 8; k++) begin
        if (u.led_out[2] === 1'b0) lows++;
        vec++; if ((u.led_out & 8'hFB) !== 8'hFB) begin miss++; $display("FAIL pwm_others got %h want ff on mask fb", u.led_out); end
        tick();
      end
      vec++; if (lows != 3) begin miss++; $display("FAIL pwm_duty3 window %0d got %0d lit want 3", w, lows); end
    end
    led_write(3'd2, 2'b11, 3'd0);
    tick();
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      if (u.led_out[2] === 1'b0) lows++;
      tick();
    end
    vec++; if (lows != 0) begin miss++; $display("FAIL pwm_duty0 got %0d lit want 0", lows); end
    led_write(3'd2, 2'b11, 3'd7);
    tick();
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      if (u.led_out[2] === 1'b0) lows++;
      tick();
    end
    vec++; if (lows != 7) begin miss++; $display("FAIL pwm_duty7 got %0d lit want 7", lows); end
    led_write(3'd0, 2'b01, 3'd0);
    tick();
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      if (u.led_out[0] === 1'b0) lows++;
      tick();
    end
    vec++; if (lows != 8) begin miss++; $display("FAIL mode_on got %0d lit want 8", lows); end
    led_write(3'd0, 2'b00, 3'd5);
    tick();
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      if (u.led_out[0] === 1'b0) lows++;
      tick();
    end
    vec++; if (lows != 0) begin miss++; $display("FAIL mode_off got %0d lit want 0", lows); end
    led_write(3'd2, 2'b11, 3'd3);
    tick();
  endtask

  task automatic test_blink_and_lamp();
    logic s [25];
    int   f;
    int   bad;
    int   lows;
    int   trans;
    led_write(3'd5, 2'b10, 3'd0);
    tick();
    for (int k = 0; k < 25; k++) begin
      s[k] = u.led_out[5];
      tick();
    end
    f = -1;
    for (int k = 1; k <= 3; k++) begin
      if (f < 0 && s[k] != s[k-1]) f = k;
    end
    vec++; if (f < 0) begin miss++; $display("FAIL blink_start got no toggle want toggle within 3 cycles"); end
    else begin
      bad = 0;
      for (int k = f; k < 25; k++) begin
        if ((s[k] != s[k-1]) != ((k - f) % 3 == 0)) bad++;
      end
      vec++; if (bad != 0) begin miss++; $display("FAIL blink_period got %0d bad cycles want 0", bad); end
    end
    u.led_test = 1'b1;
    tick();
    vec++; if (u.led_out !== 8'h00) begin miss++; $display("FAIL lamp_test got %h want 00", u.led_out); end
    tick();
    vec++; if (u.led_out !== 8'h00) begin miss++; $display("FAIL lamp_test_hold got %h want 00", u.led_out); end
    u.led_test = 1'b0;
    tick();
    vec++; if ((u.led_out & 8'hDB) !== 8'hDB) begin miss++; $display("FAIL lamp_release_off got %h want ff on mask db", u.led_out); end
    lows  = 0;
    trans = 0;
    s[0]  = u.led_out[5];
    for (int k = 0; k < 8; k++) begin
      if (u.led_out[2] === 1'b0) lows++;
      if (k > 0 && k <= 6 && u.led_out[5] != s[0]) begin trans++; s[0] = u.led_out[5]; end
      tick();
    end
    vec++; if (lows != 3) begin miss++; $display("FAIL lamp_release_pwm got %0d lit want 3", lows); end
    vec++; if (trans != 2) begin miss++; $display("FAIL lamp_release_blink got %0d toggles want 2", trans); end
  endtask

  task automatic test_wr_err();
    int pulses;
    led6_write(3'd1, 2'b01, 3'd0);
    vec++; if (v.led_wr_err !== 1'b0) begin miss++; $display("FAIL err_valid got %b want 0", v.led_wr_err); end
    tick();
    vec++; if (v.led_out !== 6'b111101) begin miss++; $display("FAIL err_setup got %b want 111101", v.led_out); end
    led6_write(3'd7, 2'b00, 3'd0);
    vec++; if (v.led_wr_err !== 1'b1) begin miss++; $display("FAIL err_idx7 got %b want 1", v.led_wr_err); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (v.led_wr_err === 1'b1) pulses++;
    end
    vec++; if (pulses != 0) begin miss++; $display("FAIL err_single got %0d extra pulses want 0", pulses); end
    vec++; if (v.led_out !== 6'b111101) begin miss++; $display("FAIL err_regs_kept got %b want 111101", v.led_out); end
    led6_write(3'd6, 2'b00, 3'd0);
    vec++; if (v.led_wr_err !== 1'b1) begin miss++; $display("FAIL err_idx6 got %b want 1", v.led_wr_err); end
    tick();
    vec++; if (v.led_wr_err !== 1'b0 || v.led_out !== 6'b111101) begin miss++; $display("FAIL err_idx6_after got err %b out %b want 0 111101", v.led_wr_err, v.led_out); end
    led6_write(3'd5, 2'b01, 3'd0);
    vec++; if (v.led_wr_err !== 1'b0) begin miss++; $display("FAIL err_idx5 got %b want 0", v.led_wr_err); end
    tick();
    vec++; if (v.led_out !== 6'b011101) begin miss++; $display("FAIL err_idx5_led got %b want 011101", v.led_out); end
    vec++; if (u.led_wr_err !== 1'b0) begin miss++; $display("FAIL err_main_quiet got %b want 0", u.led_wr_err); end
  endtask

  task automatic test_reset_mid();
    u.raw_in[3] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    vec++; if (u.db_level !== 7'h7F || u.db_fall !== 7'h00 || u.db_rise !== 7'h00) begin
      miss++; $display("FAIL midrst_db got lvl %h rise %h fall %h want 7f 00 00", u.db_level, u.db_rise, u.db_fall);
    end
    vec++; if (u.led_out !== 8'hFF) begin miss++; $display("FAIL midrst_led got %h want ff", u.led_out); end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec++; if (u.db_level[3] !== ((k >= 6) ? 1'b0 : 1'b1) || u.db_fall[3] !== (k == 6) || u.db_rise[3] !== 1'b0) begin
        miss++; $display("FAIL midrst_relatch edge %0d got lvl %b fall %b rise %b want %b %b 0", k, u.db_level[3], u.db_fall[3], u.db_rise[3], (k >= 6) ? 1'b0 : 1'b1, k == 6);
      end
      vec++; if (u.led_out !== 8'hFF) begin miss++; $display("FAIL midrst_led_after edge %0d got %h want ff", k, u.led_out); end
    end
  endtask

  initial begin
    u.raw_in = 7'h7F; u.led_wr_en = 1'b0; u.led_wr_idx = '0;
    u.led_wr_mode = 2'b00; u.led_wr_duty = '0; u.led_test = 1'b0;
    v.raw_in = 7'h7F; v.led_wr_en = 1'b0; v.led_wr_idx = '0;
    v.led_wr_mode = 2'b00; v.led_wr_duty = '0; v.led_test = 1'b0;
    test_reset();
    test_debounce_fall();
    test_debounce_rise();
    test_glitch_short();
    test_glitch_boundary();
    test_pwm();
    test_blink_and_lamp();
    test_wr_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s10_user_io_ctrl.md
S10_USER_IO_CTRL -- requirements
Module: s10_user_io_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 7, number of debounced inputs (3 pushbuttons + 4 DIP switches).
REQ-002 SHALL have parameter IN_RST_VAL, default 7'h7F, per-input debounced level after reset (inputs idle high).
REQ-003 SHALL have parameter DB_CYCLES, default 500000, consecutive cycles a changed input must persist (10 ms at 50 MHz); legal range >= 2.
REQ-004 SHALL have parameter N_LED, default 8, number of LED channels (4 green + 4 red).
REQ-005 SHALL have parameter BLINK_CYCLES, default 12500000, cycles per blink phase (2 Hz blink at 50 MHz); legal range >= 1.
REQ-006 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-007 SHALL have parameter LED_ACT_LOW, default 1; 1 = LED lit when pin is 0.
REQ-008 clk_fpga_50m  input  1  sole clock; all logic on its rising edge.
REQ-009 cpu_reset  input  1  asynchronous, active-high reset.
REQ-010 raw_in  input  N_IN  asynchronous switch/button pins.
REQ-011 db_level  output  N_IN  debounced level.
REQ-012 db_rise  output  N_IN  one-cycle pulse on debounced 0->1.
REQ-013 db_fall  output  N_IN  one-cycle pulse on debounced 1->0.
REQ-014 led_wr_en  input  1  LED configuration write strobe, one write per cycle.
REQ-015 led_wr_idx  input  clog2(N_LED) (min 1)  target channel.
REQ-016 led_wr_mode  input  2  00 off, 01 on, 10 blink, 11 PWM.
REQ-017 led_wr_duty  input  PWM_BITS  PWM duty for the channel.
REQ-018 led_wr_err  output  1  one-cycle pulse when a write targets led_wr_idx >= N_LED.
REQ-019 led_test  input  1  synchronous lamp test; forces all LEDs lit while high.
REQ-020 led_out  output  N_LED  LED pins, polarity per LED_ACT_LOW.

Function
REQ-021 Each raw_in bit SHALL pass a 2-flop synchronizer before any other use.
REQ-022 Each input SHALL own a counter of width clog2(DB_CYCLES+1); counter clears on any cycle where synchronized value equals db_level.
REQ-023 Counter SHALL increment each cycle synchronized value differs from db_level; on the cycle it would reach DB_CYCLES, db_level SHALL flip and counter SHALL clear.
REQ-024 Latency: a clean step on raw_in SHALL appear on db_level exactly DB_CYCLES+2 rising edges after the first edge sampling the new value.
REQ-025 A glitch shorter than DB_CYCLES synchronized cycles SHALL leave db_level unchanged and counter SHALL return to 0.
REQ-026 db_rise/db_fall SHALL be asserted in the same cycle db_level shows the new value, for exactly one cycle; never both on one bit.
REQ-027 Per-channel mode and duty registers SHALL load on the edge where led_wr_en=1 and led_wr_idx < N_LED; effect visible on led_out the following cycle.
REQ-028 A write with led_wr_idx >= N_LED SHALL change no register and SHALL pulse led_wr_err the next cycle.
REQ-029 A shared free-running PWM_BITS counter SHALL wrap 2^PWM_BITS-1 -> 0; PWM channel lit while counter < duty (duty 0 never lit; duty all-ones lit 2^PWM_BITS-1 of 2^PWM_BITS cycles).
REQ-030 A shared blink prescaler SHALL count 0..BLINK_CYCLES-1 and toggle blink_phase on wrap; blink channels lit while blink_phase=1; all blink channels in phase.
REQ-031 Off = never lit; on = always lit; led_test=1 SHALL override every mode to lit without altering registers.
REQ-032 led_out SHALL be registered; pin = lit XOR LED_ACT_LOW.

Reset
REQ-033 While cpu_reset=1: synchronizers and db_level = IN_RST_VAL, debounce counters 0, db_rise/db_fall 0, led_wr_err 0.
REQ-034 While cpu_reset=1: all modes off, duties 0, PWM counter 0, prescaler 0, blink_phase 0, led_out all unlit (all ones when LED_ACT_LOW=1).
REQ-035 Reset asserted mid-debounce or mid-blink SHALL abandon progress; after release counting restarts from 0 with no spurious pulse.

Verification (DB_CYCLES=4, BLINK_CYCLES=3, PWM_BITS=3, N_LED=8)
REQ-036 raw_in[0] 1->0 held -> db_level[0]=0 and db_fall[0]=1 for one cycle exactly 6 edges later; db_rise never set.
REQ-037 raw_in[1] 0-pulse of 3 synchronized cycles -> db_level[1] stays 1, no pulses.
REQ-038 Write idx=2 mode=11 duty=3 -> led_out[2] low 3 of every 8 cycles; duty=0 -> always high.
REQ-039 Write idx=5 mode=10 -> led_out[5] toggles every 3 cycles; led_test=1 -> led_out=8'h00, release restores prior pattern.
REQ-040 Write idx=9 (idx width 3 wraps? no: drive N_LED=6, idx=7) -> led_wr_err pulses once, all registers unchanged.
REQ-041 cpu_reset asserted 2 cycles into a debounce and during blink -> outputs at reset values immediately; after release full 6-edge latency required again.
